diode_matrix_bist: RTL and testbench



---
 rtl/diode_matrix_bist.sv | 98 +++++++++
 tb/tb_diode_matrix_bist.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/diode_matrix_bist.sv
// BIST sequencer for the JAM-1 ALU diode matrix: steps ALUOP 0..15, captures the
// decoded select lines and compacts them into a CRC-style signature.
//
// state   | meaning
// IDLE    | waiting for start, outputs at reset values
// SETTLE  | ALUOP held while the matrix output settles
// CAPTURE | response sampled into the signature, ALUOP advanced
// DONE    | signature frozen, pass valid, waiting for a new start

`timescale 1ns/1ps

module diode_matrix_bist #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED_SIG  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  ALUOP,
    input  logic [3:0]  LogicSelect,
    input  logic        ShiftSelectA,
    input  logic        ShiftSelectB,
    input  logic        CarrySelectA,
    input  logic        CarrySelectB,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  settle_cnt;
    logic [7:0]  resp;
    logic [15:0] sig_next;

    assign resp = {LogicSelect, ShiftSelectA, ShiftSelectB, CarrySelectA, CarrySelectB};

    // CCITT feedback taps, response folded into the low byte
    assign sig_next = ({signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000))
                    ^ {8'h00, resp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            ALUOP      <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            signature  <= 16'h0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        ALUOP      <= 4'd0;
                        signature  <= 16'h0000;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    signature <= sig_next;
                    if (ALUOP == 4'hF) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (sig_next == EXPECTED_SIG);
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        ALUOP      <= ALUOP + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diode_matrix_bist.sv
// Directed + randomized bench for diode_matrix_bist; two instances cover
// SETTLE_CYCLES=2 and SETTLE_CYCLES=1 against a per-opcode signature model.

`timescale 1ns/1ps

module tb_diode_matrix_bist;

    localparam logic [15:0] EXP0 = 16'h0000;
    localparam logic [15:0] EXP1 = 16'h0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start0, start1;
    logic [3:0]  aluop0, aluop1;
    logic [3:0]  ls0, ls1;
    logic        ssa0, ssb0, csa0, csb0, ssa1, ssb1, csa1, csb1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] sig0, sig1;

    logic [7:0] tab0 [16];
    logic [7:0] tab1 [16];

    // behavioural diode matrix: response is a lookup on the current opcode
    assign {ls0, ssa0, ssb0, csa0, csb0} = tab0[aluop0];
    assign {ls1, ssa1, ssb1, csa1, csb1} = tab1[aluop1];

    diode_matrix_bist #(.SETTLE_CYCLES(2), .EXPECTED_SIG(EXP0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .ALUOP(aluop0),
        .LogicSelect(ls0), .ShiftSelectA(ssa0), .ShiftSelectB(ssb0),
        .CarrySelectA(csa0), .CarrySelectB(csb0),
        .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
    );

    diode_matrix_bist #(.SETTLE_CYCLES(1), .EXPECTED_SIG(EXP1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ALUOP(aluop1),
        .LogicSelect(ls1), .ShiftSelectA(ssa1), .ShiftSelectB(ssb1),
        .CarrySelectA(csa1), .CarrySelectB(csb1),
        .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0]  f_aluop(input int w); return (w == 0) ? aluop0 : aluop1; endfunction
    function automatic logic        f_busy (input int w); return (w == 0) ? busy0  : busy1;  endfunction
    function automatic logic        f_done (input int w); return (w == 0) ? done0  : done1;  endfunction
    function automatic logic        f_pass (input int w); return (w == 0) ? pass0  : pass1;  endfunction
    function automatic logic [15:0] f_sig  (input int w); return (w == 0) ? sig0   : sig1;   endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 0) start0 = v;
        else        start1 = v;
    endtask

    // signature after one full sweep: shift-with-feedback then fold in each response
    function automatic logic [15:0] model_sig(input int w);
        int s = 0;
        for (int op = 0; op < 16; op++) begin
            int r = (w == 0) ? int'(tab0[op]) : int'(tab1[op]);
            int fb = (s >= 32768) ? 32'h1021 : 0;
            s = ((s * 2) % 65536) ^ fb ^ r;
        end
        return 16'(s);
    endfunction

    task automatic run(input int w, input int settle, input logic [15:0] exp_sig,
                       input logic [15:0] golden, input bit poke);
        int cyc, hold, overlap, gaps;
        logic [3:0] prev;
        bit seen_done;
        @(negedge clk); set_start(w, 1'b1);
        @(negedge clk); set_start(w, 1'b0);
        check("start_busy",  32'(f_busy(w)),  32'd1);
        check("start_done",  32'(f_done(w)),  32'd0);
        check("start_aluop", 32'(f_aluop(w)), 32'd0);
        check("start_sig",   32'(f_sig(w)),   32'd0);
        cyc = 1; hold = 1; prev = 4'd0; seen_done = 0; overlap = 0; gaps = 0;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            if (poke && cyc == 5) set_start(w, 1'b1);
            if (poke && cyc == 6) set_start(w, 1'b0);
            if (f_busy(w) && f_done(w)) overlap++;
            if (f_done(w)) begin
                seen_done = 1;
            end else begin
                if (!f_busy(w)) gaps++;
                cyc++;
                if (f_aluop(w) != prev) begin
                    check("aluop_step", 32'(f_aluop(w)), 32'(prev) + 32'd1);
                    check("aluop_hold", 32'(hold), 32'(settle + 1));
                    prev = f_aluop(w);
                    hold = 1;
                end else begin
                    hold++;
                end
            end
        end
        set_start(w, 1'b0);
        check("done_seen",    32'(seen_done), 32'd1);
        check("run_len",      32'(cyc), 32'(16 * (settle + 1)));
        check("last_hold",    32'(hold), 32'(settle + 1));
        check("busy_done_ex", 32'(overlap), 32'd0);
        check("busy_gaps",    32'(gaps), 32'd0);
        check("done_aluop",   32'(f_aluop(w)), 32'd15);
        check("done_busy",    32'(f_busy(w)), 32'd0);
        check("done_sig",     32'(f_sig(w)), 32'(exp_sig));
        check("done_pass",    32'(f_pass(w)), 32'(exp_sig == golden));
        repeat (3) @(negedge clk);
        check("frozen_sig",   32'(f_sig(w)), 32'(exp_sig));
        check("frozen_done",  32'(f_done(w)), 32'd1);
        check("frozen_aluop", 32'(f_aluop(w)), 32'd15);
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < 16; i++) begin
            tab0[i] = 8'h00;
            tab1[i] = 8'h00;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_aluop"}, 32'(aluop0), 32'd0);
        check({tag, "_busy"},  32'(busy0),  32'd0);
        check({tag, "_done"},  32'(done0),  32'd0);
        check({tag, "_pass"},  32'(pass0),  32'd0);
        check({tag, "_sig"},   32'(sig0),   32'd0);
    endtask

    initial begin
        int guard;
        logic [15:0] exp_r;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        clear_tabs();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;

        // all-zero matrix response
        run(0, 2, 16'h0000, EXP0, 1'b0);

        // single low-bit response at the last and second-to-last opcode
        tab0[15] = 8'h01;
        run(0, 2, 16'h0001, EXP0, 1'b0);
        clear_tabs(); tab0[14] = 8'h01;
        run(0, 2, 16'h0002, EXP0, 1'b0);

        // MSB response at opcode 0 exercises the feedback polynomial
        clear_tabs(); tab0[0] = 8'h80;
        run(0, 2, 16'h48C4, EXP0, 1'b0);

        // random response with a stray start during the run
        for (int i = 0; i < 16; i++) tab0[i] = 8'($urandom);
        exp_r = model_sig(0);
        run(0, 2, exp_r, EXP0, 1'b1);
        for (int i = 0; i < 16; i++) tab0[i] = 8'($urandom);
        exp_r = model_sig(0);
        run(0, 2, exp_r, EXP0, 1'b0);

        // asynchronous reset in the middle of a run
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        guard = 0;
        while (aluop0 != 4'd7 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("reach_op7", 32'(aluop0), 32'd7);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk); rst = 1'b0;
        clear_tabs();
        run(0, 2, 16'h0000, EXP0, 1'b0);

        // SETTLE_CYCLES=1 instance
        run(1, 1, 16'h0000, EXP1, 1'b0);
        for (int i = 0; i < 16; i++) tab1[i] = 8'($urandom);
        exp_r = model_sig(1);
        run(1, 1, exp_r, EXP1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
